// File: rtl/note_recorder.sv
`default_nettype none
// ============================================================================
// Module      : note_recorder
// Description : Measures the dominant tone's half-period from live microphone
//               samples (hysteresis zero-crossing detector plus saturating
//               period counter) and, once per beat, writes that measurement
//               into the note RAM in the tone player's delay-counter format.
// Revision    : 1.0 - initial release
// ============================================================================
module note_recorder #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 18,
    parameter int BEAT_CYCLES = 3125000,
    parameter int MAX_ADDR    = 729,
    parameter int THRESH      = 1000000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                audio_in_available,
    input  logic signed [31:0]  audio_in_sample,
    output logic                read_audio_in,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_wren,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   cur_address
);

    // Beat counter only needs to reach BEAT_CYCLES-1.
    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

    localparam logic [DATA_W-1:0]  c_per_max    = '1;
    localparam logic [DATA_W-1:0]  c_per_near   = c_per_max - 1'b1;
    localparam logic [BEAT_W-1:0]  c_beat_last  = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  c_addr_last  = ADDR_W'(MAX_ADDR);
    localparam logic signed [31:0] c_thresh_pos = 32'(THRESH);
    localparam logic signed [31:0] c_thresh_neg = 32'(-THRESH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                pos_q, pos_d;
    logic [DATA_W-1:0]   per_q, per_d;
    logic [DATA_W-1:0]   last_half_q, last_half_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                ram_wren_q, ram_wren_d;
    logic                crossing;

    // Every available sample is popped, regardless of state or reset.
    assign read_audio_in = audio_in_available;

    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = (state_q == ST_RECORD);
    assign done        = (state_q == ST_DONE);
    assign cur_address = addr_q;

    // Zero-crossing detector: polarity flips only when a sample clears the
    // hysteresis band on the opposite side.
    always_comb begin
        pos_d    = pos_q;
        crossing = 1'b0;
        if (audio_in_available) begin
            if (!pos_q && (audio_in_sample > c_thresh_pos)) begin
                pos_d    = 1'b1;
                crossing = 1'b1;
            end else if (pos_q && (audio_in_sample < c_thresh_neg)) begin
                pos_d    = 1'b0;
                crossing = 1'b1;
            end
        end
    end

    // Period counter: a crossing latches the elapsed count (t1-t0-1, the
    // player's delay value) and restarts; reaching saturation means silence.
    always_comb begin
        per_d       = per_q;
        last_half_d = last_half_q;
        if (crossing) begin
            per_d       = '0;
            last_half_d = per_q;
        end else if (per_q != c_per_max) begin
            per_d = per_q + 1'b1;
            if (per_q == c_per_near) begin
                last_half_d = '0;
            end
        end
    end

    // Recording FSM: one RAM write per beat, addresses 0..MAX_ADDR.
    // The written word is last_half before this edge, so a crossing that
    // lands on the beat boundary only affects the following beat.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RECORD;
                    addr_d  = '0;
                    beat_d  = '0;
                end
            end
            ST_RECORD: begin
                if (beat_q == c_beat_last) begin
                    ram_wren_d    = 1'b1;
                    ram_address_d = addr_q;
                    ram_data_d    = last_half_q;
                    beat_d        = '0;
                    if (addr_q == c_addr_last) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pos_q         <= 1'b0;
            per_q         <= '0;
            last_half_q   <= '0;
            beat_q        <= '0;
            addr_q        <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            per_q         <= per_d;
            last_half_q   <= last_half_d;
            beat_q        <= beat_d;
            addr_q        <= addr_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_recorder
// Description : Scoreboard bench for note_recorder. Expected RAM writes are
//               queued when a recording is started and popped as the DUT
//               strobes ram_wren.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_recorder;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int BEAT   = 1000;
    localparam int MAXA   = 3;
    localparam int THRESH = 1000000;
    localparam int BIG    = 10000000;
    localparam int QUIET  = 500000;

    logic                CLOCK_50 = 1'b0;
    logic                reset;
    logic                start;
    logic                audio_in_available;
    logic signed [31:0]  audio_in_sample;
    logic                read_audio_in;
    logic [ADDR_W-1:0]   ram_address;
    logic [DATA_W-1:0]   ram_data;
    logic                ram_wren;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   cur_address;

    note_recorder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BEAT_CYCLES (BEAT),
        .MAX_ADDR    (MAXA),
        .THRESH      (THRESH)
    ) dut (
        .CLOCK_50           (CLOCK_50),
        .reset              (reset),
        .start              (start),
        .audio_in_available (audio_in_available),
        .audio_in_sample    (audio_in_sample),
        .read_audio_in      (read_audio_in),
        .ram_address        (ram_address),
        .ram_data           (ram_data),
        .ram_wren           (ram_wren),
        .busy               (busy),
        .done               (done),
        .cur_address        (cur_address)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_data(input int mode, input int k);
        case (mode)
            2:       return (k == 1) ? 255 : 0;
            3:       return (k == 0) ? 29 : 39;
            default: return 49;
        endcase
    endfunction

    task automatic push_writes(input int base, input int count, input int mode);
        for (int k = 0; k < count; k++) begin
            exp_q.push_back('{base + BEAT * (k + 1), k, exp_data(mode, k)});
        end
    endtask

    // Edges (relative to the start edge) on which the input tone crosses.
    function automatic bit cross_at(input int mode, input int n);
        case (mode)
            2:       return (n >= -300 && n <= -100 && (n % 20) == 0) || n == 1900;
            3:       return (n > 0 && n <= 960 && (n % 30) == 0) ||
                            (n >= 1000 && ((n - 1000) % 40) == 0);
            default: return (n % 50) == 0;
        endcase
    endfunction

    function automatic bit quiet_at(input int mode, input int n);
        return (mode == 2) && (n > -100);
    endfunction

    function automatic bit start_at(input int mode, input int n);
        case (mode)
            4:       return (n >= 0 && n <= 4000) || n == 4010;
            5:       return n == 0 || n == 3600;
            default: return n == 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Write strobes are matched against the scoreboard; the FIFO pop must
    // mirror availability at all times.
    always @(negedge CLOCK_50) begin
        check("rd_mirror", read_audio_in, audio_in_available);
        if (ram_wren) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr", ram_address, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_cyc", cyc, e.cyc);
                check("wr_addr", ram_address, e.addr);
                check("wr_data", ram_data, e.data);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start              = 1'($urandom);
            audio_in_available = 1'($urandom);
            audio_in_sample    = $urandom;
            tick();
            check("rst_wren", ram_wren, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_cur", cur_address, 0);
            check("rst_addr", ram_address, 0);
            check("rst_data", ram_data, 0);
        end
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic run(input int mode, input int n_lo, input int n_hi);
        bit lvl = 1'b0;
        for (int n = n_lo; n <= n_hi; n++) begin
            reset              = (mode == 5) && (n == 2010 || n == 2011);
            start              = start_at(mode, n);
            audio_in_available = 1'b1;
            if (cross_at(mode, n)) begin
                lvl             = ~lvl;
                audio_in_sample = lvl ? BIG : -BIG;
            end else if (quiet_at(mode, n)) begin
                audio_in_sample = ((n % 2) == 0) ? QUIET : -QUIET;
            end else begin
                audio_in_sample = lvl ? BIG : -BIG;
            end
            tick();
            if (n == 0)                  push_writes(cyc, (mode == 5) ? 2 : 4, mode);
            if (mode == 4 && n == 4010)  push_writes(cyc, 4, mode);
            if (mode == 5 && n == 3600)  push_writes(cyc, 1, mode);
            case (mode)
                1: begin
                    if (n == 0)    begin check("p_busy0", busy, 1); check("p_done0", done, 0); end
                    if (n == 1500) check("p_cur1", cur_address, 1);
                    if (n == 3999) check("p_busy_last", busy, 1);
                    if (n == 4000) begin check("p_busy_end", busy, 0); check("p_done_end", done, 1); end
                    if (n == 4010) begin
                        check("p_hold_addr", ram_address, 3);
                        check("p_hold_data", ram_data, 49);
                        check("p_cur_end", cur_address, 3);
                    end
                end
                4: begin
                    if (n == 2500) begin check("s_cur2", cur_address, 2); check("s_busy", busy, 1); end
                    if (n == 4005) check("s_done", done, 1);
                    if (n == 4010) begin
                        check("s_restart_busy", busy, 1);
                        check("s_restart_done", done, 0);
                        check("s_restart_cur", cur_address, 0);
                    end
                    if (n == 8010) check("s_done2", done, 1);
                end
                5: begin
                    if (n == 2011) begin
                        check("m_busy", busy, 0);
                        check("m_cur", cur_address, 0);
                        check("m_addr", ram_address, 0);
                        check("m_data", ram_data, 0);
                    end
                    if (n == 2500) check("m_idle", busy, 0);
                    if (n == 3600) check("m_busy_again", busy, 1);
                end
                default: begin
                    if (n == 4010) check("done_end", done, 1);
                end
            endcase
        end
        reset = 1'b0;
        start = 1'b0;
        check("pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset              = 1'b1;
        start              = 1'b0;
        audio_in_available = 1'b0;
        audio_in_sample    = '0;
        do_reset();
        run(1, -200, 4010);
        do_reset();
        run(2, -300, 4010);
        do_reset();
        run(3, 0, 4010);
        do_reset();
        run(4, -200, 8020);
        do_reset();
        run(5, -200, 4620);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_recorder.md
# note_recorder

Captures live microphone audio from the audio controller's input FIFO and measures the dominant tone's half-period in CLOCK_50 cycles. Once per beat it writes that measurement into the note RAM. The stored word uses the same format the tone player loads into its square-wave delay counter, so a recorded melody plays back at pitch. The block sits between the audio controller's read side and the note RAM's write port.

## Interface
- ADDR_W, 10, note RAM address width
- DATA_W, 18, half-period word width; also the period counter width
- BEAT_CYCLES, 3125000, CLOCK_50 cycles per beat
- MAX_ADDR, 729, last address written
- THRESH, 1000000, hysteresis magnitude for zero-crossing detection (signed 32-bit)
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begins a recording from address 0; level-sampled
- audio_in_available  in  1  audio controller has a sample ready
- audio_in_sample  in  32  signed left-channel sample
- read_audio_in  out  1  pops the sample; combinational, equal to audio_in_available
- ram_address  out  ADDR_W  note RAM write address
- ram_data  out  DATA_W  note RAM write data
- ram_wren  out  1  one-cycle write strobe
- busy  out  1  high in RECORD
- done  out  1  high in DONE
- cur_address  out  ADDR_W  next address to be written, for hex display

## Operation
- Sample capture: a sample is consumed on every cycle where audio_in_available=1, in all states.
- Zero-crossing detector with hysteresis; polarity register pos:
  - If a consumed sample is greater than +THRESH and pos=0: set pos=1, crossing.
  - If a consumed sample is less than −THRESH and pos=1: set pos=0, crossing.
  - Samples within ±THRESH never cause a crossing.
- Period counter per (DATA_W bits, runs in all states):
  - On a crossing edge: per ← 0, and last_half ← per's pre-edge value.
  - Otherwise: per ← per+1, saturating at 2^DATA_W−1.
  - Result: crossings at edges t0 and t1 store t1−t0−1, which is the player's delay value for a half-period of t1−t0 cycles.
- Silence: on the edge where per reaches saturation, last_half ← 0. Code 0 means no tone.
- FSM states and transitions:
  - IDLE: start=1 → RECORD; addr←0; beat←0.
  - RECORD: beat counts 0..BEAT_CYCLES−1. On the edge with beat=BEAT_CYCLES−1:
    - ram_wren←1, ram_address←addr, ram_data←last_half (pre-edge value), beat←0.
    - If addr=MAX_ADDR → DONE; else addr←addr+1.
    - start is ignored in RECORD.
  - DONE: start=1 → RECORD with addr←0, beat←0.
- Crossing and beat terminal on the same edge: the written word is the last_half value before the crossing; the new measurement applies to the next beat.
- Arithmetic: per saturates and never wraps. addr never exceeds MAX_ADDR.

## Timing
- Reset values: ram_address=0, ram_data=0, ram_wren=0, busy=0, done=0, cur_address=0; internally pos=0, per=0, last_half=0, beat=0, state IDLE. read_audio_in follows audio_in_available even while reset is high.
- start sampled at edge E0 → busy=1 from E0+1.
- First ram_wren is visible for the cycle following edge E0+BEAT_CYCLES. Subsequent writes are exactly BEAT_CYCLES cycles apart.
- ram_wren is high for exactly one cycle per beat. ram_address and ram_data hold their values until the next write.
- The final write (to MAX_ADDR) coincides with done rising; busy falls on the same edge.
- Reset mid-RECORD: the next cycle is in reset state, with no further ram_wren and cur_address=0.
- last_half updates one edge after the crossing sample is consumed.

## Test plan
- Reset: assert reset for 3 cycles with random inputs → all outputs 0, ram_wren never high, read_audio_in mirrors audio_in_available.
- Pitch measure (BEAT_CYCLES=1000, MAX_ADDR=3): available every cycle, sample +10000000 for 50 cycles then −10000000 for 50 cycles, repeating. Pulse start → four writes at addresses 0,1,2,3 with data 49, then done=1 and busy=0.
- Hysteresis: samples alternating ±500000 (inside THRESH) with DATA_W=8 → no crossings, per saturates at 255, all written words 0.
- Coincident events: force a crossing on the same edge as beat=BEAT_CYCLES−1 → written word equals the prior last_half; the next beat writes the new value.
- Start handling: start held high through RECORD → no restart and addresses 0..3 in order. start in DONE → new write sequence from address 0.
- Reset mid-record after the write to address 1 → ram_wren stays low and cur_address=0. A later start writes address 0 first.
